// File: rtl/wave_ctrl.sv
// Rate sequencer for the waveform generator: prescaled phase stepping, burst period
// counting, and a valid/ready sample port with sticky overrun on overwritten samples.
module wave_ctrl #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       div,
  input  logic [7:0]       step,
  input  logic [SEL_W-1:0] sel,
  input  logic [7:0]       burst,
  input  logic [7:0]       square,
  input  logic [7:0]       reciprocal,
  input  logic [7:0]       triangle,
  input  logic [7:0]       sin_out,
  input  logic [7:0]       fullrect,
  input  logic [7:0]       halfrect,
  input  logic             sample_ready,
  output logic [7:0]       count_out,
  output logic             tick,
  output logic [7:0]       sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [7:0]       presc, presc_nxt;
  logic [7:0]       periods, periods_nxt;
  logic [7:0]       div_l, div_l_nxt;
  logic [7:0]       step_l, step_l_nxt;
  logic [SEL_W-1:0] sel_l, sel_l_nxt;
  logic [7:0]       burst_l, burst_l_nxt;
  logic             done_pend, done_pend_nxt;
  logic [7:0]       count_nxt, sample_nxt;
  logic             tick_nxt, valid_nxt, done_nxt, overrun_nxt;
  logic [8:0]       sum;
  logic [7:0]       sel_val;

  always_comb begin
    case (sel_l)
      SEL_W'(0): sel_val = square;
      SEL_W'(1): sel_val = reciprocal;
      SEL_W'(2): sel_val = triangle;
      SEL_W'(3): sel_val = sin_out;
      SEL_W'(4): sel_val = fullrect;
      SEL_W'(5): sel_val = halfrect;
      default:   sel_val = 8'h00;
    endcase
  end

  assign sum = {1'b0, count_out} + {1'b0, step_l};

  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    periods_nxt   = periods;
    div_l_nxt     = div_l;
    step_l_nxt    = step_l;
    sel_l_nxt     = sel_l;
    burst_l_nxt   = burst_l;
    done_pend_nxt = done_pend;
    count_nxt     = count_out;
    sample_nxt    = sample;
    tick_nxt      = 1'b0;
    done_nxt      = 1'b0;
    overrun_nxt   = overrun;
    // A step event on the same edge re-asserts valid below.
    valid_nxt     = sample_valid & ~sample_ready;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          div_l_nxt     = div;
          step_l_nxt    = step;
          sel_l_nxt     = sel;
          burst_l_nxt   = burst;
          count_nxt     = 8'h00;
          presc_nxt     = 8'h00;
          periods_nxt   = 8'h00;
          overrun_nxt   = 1'b0;
          done_pend_nxt = 1'b0;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          done_pend_nxt = 1'b0;
          state_nxt     = DRAIN;
        end else if (presc == div_l) begin
          presc_nxt  = 8'h00;
          count_nxt  = sum[7:0];
          sample_nxt = sel_val;
          valid_nxt  = 1'b1;
          tick_nxt   = 1'b1;
          if (sample_valid && !sample_ready) overrun_nxt = 1'b1;
          if (sum[8]) begin
            periods_nxt = periods + 8'd1;
            if (burst_l != 8'h00 && periods_nxt == burst_l) begin
              done_pend_nxt = 1'b1;
              state_nxt     = DRAIN;
            end
          end
        end else begin
          presc_nxt = presc + 8'd1;
        end
      end
      DRAIN: begin
        if (!sample_valid || sample_ready) begin
          done_nxt  = done_pend;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      presc        <= 8'h00;
      periods      <= 8'h00;
      div_l        <= 8'h00;
      step_l       <= 8'h00;
      sel_l        <= '0;
      burst_l      <= 8'h00;
      done_pend    <= 1'b0;
      count_out    <= 8'h00;
      tick         <= 1'b0;
      sample       <= 8'h00;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      periods      <= periods_nxt;
      div_l        <= div_l_nxt;
      step_l       <= step_l_nxt;
      sel_l        <= sel_l_nxt;
      burst_l      <= burst_l_nxt;
      done_pend    <= done_pend_nxt;
      count_out    <= count_nxt;
      tick         <= tick_nxt;
      sample       <= sample_nxt;
      sample_valid <= valid_nxt;
      busy         <= (state_nxt != IDLE);
      done         <= done_nxt;
      overrun      <= overrun_nxt;
    end
  end

endmodule
